button_io: RTL and testbench

//   Memory-mapped pushbutton input peripheral for the reptile CPU system.

---
 rtl/button_io.sv | 53 +++++
 tb/tb_button_io.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/button_io.sv
// button_io: synchronised, debounced pushbutton peripheral with a press counter and a sticky pending flag.
module button_io #(
   parameter logic [11:0] BASE_ADDR       = 12'hFF0,
   parameter int          DEBOUNCE_CYCLES = 50000,
   parameter bit          ACTIVE_LOW      = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pushbutton,
   input  logic [11:0] address,
   input  logic [15:0] data_out,
   input  logic        memwt,
   output logic        hit,
   output logic [15:0] rd_data,
   output logic        irq
);
   localparam int W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [W-1:0] DEB_MAX = W'(DEBOUNCE_CYCLES - 1);

   logic         sync_d, sync_q, stable, pending;
   logic [W-1:0] deb_cnt;
   logic [15:0]  press_cnt;
   logic         hit_status, hit_count, commit, press, wr_status, wr_count;

   assign hit_status = address == BASE_ADDR;
   assign hit_count  = address == BASE_ADDR + 12'd1;
   assign hit        = hit_status | hit_count;
   assign rd_data    = hit_status ? {14'b0, pending, stable} : hit_count ? press_cnt : 16'h0000;
   assign irq        = pending;
   assign wr_status  = memwt & hit_status;
   assign wr_count   = memwt & hit_count;
   assign commit     = (sync_q != stable) && (deb_cnt == DEB_MAX);
   assign press      = commit & sync_q;

   // set beats a same-cycle clear; a count clear is applied before the new press is added
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_d    <= 1'b0;
         sync_q    <= 1'b0;
         stable    <= 1'b0;
         deb_cnt   <= '0;
         pending   <= 1'b0;
         press_cnt <= 16'h0000;
      end else begin
         sync_d    <= pushbutton ^ ACTIVE_LOW;
         sync_q    <= sync_d;
         deb_cnt   <= (sync_q == stable || commit) ? '0 : deb_cnt + 1'b1;
         if (commit) stable <= sync_q;
         pending   <= press | (pending & ~(wr_status & data_out[1]));
         press_cnt <= (wr_count ? 16'h0000 : press_cnt) + {15'b0, press};
      end
   end
endmodule

// File: tb/tb_button_io.sv
// tb_button_io: directed scoreboard bench for button_io with a 4-cycle debounce.
module tb_button_io;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pushbutton = 1'b0;
   logic [11:0] address = 12'h010;
   logic [15:0] data_out = 16'h0000;
   logic        memwt = 1'b0;
   logic        hit, irq;
   logic [15:0] rd_data;
   logic [15:0] exp_q[$];
   int          checks = 0;
   int          fails = 0;

   button_io #(.BASE_ADDR(12'hFF0), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .pushbutton(pushbutton), .address(address),
      .data_out(data_out), .memwt(memwt), .hit(hit), .rd_data(rd_data), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input logic [15:0] v);
      exp_q.push_back(v);
   endtask

   task automatic chk(input string tag, input logic [15:0] obs);
      logic [15:0] e;
      checks++;
      if (exp_q.size() == 0) begin
         fails++;
         $error("FAIL %s: got %h but scoreboard empty", tag, obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, e);
         end
      end
   endtask

   task automatic rd(input string tag, input logic [11:0] a, input logic [15:0] exp_rd, input logic exp_hit);
      address = a;
      #1;
      push(exp_rd);
      chk({tag, "_rd"}, rd_data);
      push({15'b0, exp_hit});
      chk({tag, "_hit"}, {15'b0, hit});
   endtask

   task automatic chk_irq(input string tag, input logic e);
      #1;
      push({15'b0, e});
      chk(tag, {15'b0, irq});
   endtask

   task automatic wr(input logic [11:0] a, input logic [15:0] d);
      address = a;
      data_out = d;
      memwt = 1'b1;
      tick(1);
      memwt = 1'b0;
      address = 12'h010;
   endtask

   task automatic press_release();
      pushbutton = 1'b1;
      tick(10);
      pushbutton = 1'b0;
      tick(10);
   endtask

   initial begin
      tick(3);
      rd("rst_status_in_reset", 12'hFF0, 16'h0000, 1'b1);
      rst_n = 1'b1;
      tick(1);
      rd("rst_status", 12'hFF0, 16'h0000, 1'b1);
      rd("rst_count", 12'hFF1, 16'h0000, 1'b1);
      rd("miss", 12'h010, 16'h0000, 1'b0);
      chk_irq("rst_irq", 1'b0);
      // clean press: irq rises on the 6th edge after the button is raised
      pushbutton = 1'b1;
      tick(5);
      chk_irq("press_irq_early", 1'b0);
      tick(1);
      chk_irq("press_irq", 1'b1);
      tick(4);
      rd("press_status", 12'hFF0, 16'h0003, 1'b1);
      rd("press_count", 12'hFF1, 16'h0001, 1'b1);
      pushbutton = 1'b0;
      tick(10);
      rd("release_status", 12'hFF0, 16'h0002, 1'b1);
      wr(12'hFF0, 16'h0002);
      wr(12'hFF1, 16'h0000);
      rd("cleared_status", 12'hFF0, 16'h0000, 1'b1);
      rd("cleared_count", 12'hFF1, 16'h0000, 1'b1);
      // bounce: pulses of 1, 2 and 3 cycles never qualify
      pushbutton = 1'b1; tick(1); pushbutton = 1'b0; tick(1);
      pushbutton = 1'b1; tick(2); pushbutton = 1'b0; tick(1);
      pushbutton = 1'b1; tick(3); pushbutton = 1'b0; tick(8);
      rd("bounce_status", 12'hFF0, 16'h0000, 1'b1);
      rd("bounce_count", 12'hFF1, 16'h0000, 1'b1);
      chk_irq("bounce_irq", 1'b0);
      // pending clear, and clears racing the press event
      pushbutton = 1'b1;
      tick(10);
      rd("p4_status", 12'hFF0, 16'h0003, 1'b1);
      wr(12'hFF0, 16'h0001);
      rd("bit0_write_ignored", 12'hFF0, 16'h0003, 1'b1);
      wr(12'hFF0, 16'h0002);
      rd("pending_clear", 12'hFF0, 16'h0001, 1'b1);
      pushbutton = 1'b0;
      tick(10);
      pushbutton = 1'b1;
      tick(5);
      address = 12'hFF0; data_out = 16'h0002; memwt = 1'b1;
      tick(1);
      memwt = 1'b0;
      rd("set_wins_status", 12'hFF0, 16'h0003, 1'b1);
      rd("set_wins_count", 12'hFF1, 16'h0002, 1'b1);
      pushbutton = 1'b0;
      tick(10);
      pushbutton = 1'b1;
      tick(5);
      address = 12'hFF1; data_out = 16'hABCD; memwt = 1'b1;
      tick(1);
      memwt = 1'b0;
      rd("clear_then_count", 12'hFF1, 16'h0001, 1'b1);
      pushbutton = 1'b0;
      tick(10);
      // counter wrap from a preloaded value
      force dut.press_cnt = 16'hFFFF;
      #1;
      release dut.press_cnt;
      rd("preload", 12'hFF1, 16'hFFFF, 1'b1);
      press_release();
      rd("wrap", 12'hFF1, 16'h0000, 1'b1);
      press_release();
      rd("after_wrap", 12'hFF1, 16'h0001, 1'b1);
      wr(12'hFF1, 16'h1234);
      rd("count_clear", 12'hFF1, 16'h0000, 1'b1);
      // reset mid-debounce with the button held
      pushbutton = 1'b1;
      tick(4);
      rst_n = 1'b0;
      #1;
      rd("midrst_status", 12'hFF0, 16'h0000, 1'b1);
      rd("midrst_count", 12'hFF1, 16'h0000, 1'b1);
      chk_irq("midrst_irq", 1'b0);
      tick(2);
      rst_n = 1'b1;
      tick(5);
      chk_irq("postrst_irq_early", 1'b0);
      tick(1);
      chk_irq("postrst_irq", 1'b1);
      rd("postrst_count", 12'hFF1, 16'h0001, 1'b1);
      tick(6);
      rd("postrst_once", 12'hFF1, 16'h0001, 1'b1);
      pushbutton = 1'b0;
      tick(10);
      rd("final_status", 12'hFF0, 16'h0002, 1'b1);
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end
endmodule
